instr_mem_loader: RTL

- Parametrised instruction memory for the single-cycle/pipelined LEGv8 datapath.
- Replaces fixed-size memory with hard-coded contents.
- Contents are streamed in over a valid/ready load port after reset; fetches then proceed over a request/valid port.
- Fetch addresses are byte addresses from the PC. Misaligned and out-of-range fetches are flagged, never silently wrapped.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/instr_mem_loader_if.sv | 42 ++++
 rtl/imem_ram.sv | 37 +++
 rtl/instr_mem_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants and types for the LEGv8 instruction memory
//                loader: fault codes, controller states and the NOP encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

   // Fault codes reported alongside every fetched word
   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   // LEGv8 NOP, returned in place of data on a faulting fetch
   localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

   // Controller states
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } imem_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Load (valid/ready) and fetch (request/valid) bundle of the
//                instruction memory. The master side streams the program and
//                issues fetches; the slave side is the memory.
//  Ports       : load_start/valid/data/last -> memory, load_ready/loaded <-
//                fetch_req/addr, instr_stall -> memory,
//                fetch_ready/instr_valid/instruction/instr_fault <-
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  loaded;
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_ready;
   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instruction;
   logic [1:0]            instr_fault;
   logic                  instr_stall;

   modport master (
      output load_start, load_valid, load_data, load_last,
      output fetch_req, fetch_addr, instr_stall,
      input  load_ready, loaded, fetch_ready, instr_valid, instruction, instr_fault
   );

   modport slave (
      input  load_start, load_valid, load_data, load_last,
      input  fetch_req, fetch_addr, instr_stall,
      output load_ready, loaded, fetch_ready, instr_valid, instruction, instr_fault
   );
endinterface
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : Plain 1R1W synchronous RAM, DEPTH x DATA_WIDTH, registered
//                read without reset so it maps onto block RAM.
//  Ports       : clock, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read),
//                rdata_o (read data, one cycle after re_i, held otherwise)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Parametrised LEGv8 instruction memory. The program is
//                streamed in after reset, then fetched by byte address with
//                misaligned / out-of-range fetches flagged (never wrapped).
//  Ports       : clock, reset_n (synchronous, active low),
//                bus (instr_mem_loader_if.slave: load and fetch ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
   import imem_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(LEGV8_NOP)
) (
   input  logic               clock,
   input  logic               reset_n,
   instr_mem_loader_if.slave  bus
);
   localparam int OFFS   = $clog2(DATA_WIDTH / 8);
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_WIDTH-1:0] ONE_A     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = (ONE_A << OFFS) - ONE_A;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
   localparam logic [RAM_AW-1:0]     LAST_WPTR = RAM_AW'(DEPTH - 1);

   imem_state_e       state_q, state_d;
   logic [RAM_AW-1:0] wptr_q, wptr_d;
   logic              loaded_q, loaded_d;
   logic              valid_q, valid_d;
   logic [1:0]        fault_q, fault_d;
   logic              out_seen_q, out_seen_d;

   logic                  w_load_hs;
   logic                  w_fetch_ready;
   logic                  w_fetch_acc;
   logic [ADDR_WIDTH-1:0] w_index;
   logic                  w_misalign;
   logic                  w_range;
   logic [1:0]            w_fetch_fault;
   logic [DATA_WIDTH-1:0] w_rdata;

   // load_start outranks any handshake in the same cycle
   assign w_load_hs     = (state_q == ST_LOAD) & bus.load_valid & ~bus.load_start;
   assign w_fetch_ready = (state_q == ST_RUN) & ~(valid_q & bus.instr_stall);
   assign w_fetch_acc   = bus.fetch_req & w_fetch_ready & ~bus.load_start;

   // Range check on the full-width index so high address bits cannot alias
   assign w_index       = bus.fetch_addr >> OFFS;
   assign w_misalign    = (bus.fetch_addr & OFFS_MASK) != '0;
   assign w_range       = w_index >= DEPTH_A;
   assign w_fetch_fault = w_misalign ? FAULT_MISALIGN :
                          w_range    ? FAULT_RANGE    : FAULT_OK;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      loaded_d   = loaded_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      out_seen_d = out_seen_q;
      if (bus.load_start) begin
         state_d  = ST_LOAD;
         wptr_d   = '0;
         loaded_d = 1'b0;
         valid_d  = 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (w_load_hs) begin
                  wptr_d = wptr_q + RAM_AW'(1);
                  if (bus.load_last || (wptr_q == LAST_WPTR)) begin
                     state_d  = ST_RUN;
                     loaded_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_fetch_acc) begin
                  valid_d    = 1'b1;
                  fault_d    = w_fetch_fault;
                  out_seen_d = 1'b1;
               end else if (!(valid_q && bus.instr_stall)) begin
                  valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= ST_EMPTY;
         wptr_q     <= '0;
         loaded_q   <= 1'b0;
         valid_q    <= 1'b0;
         fault_q    <= FAULT_OK;
         out_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         loaded_q   <= loaded_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         out_seen_q <= out_seen_d;
      end
   end

   // The RAM output register only updates on a good fetch, so it also acts as
   // the hold register during a stall and across faulting fetches.
   imem_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (RAM_AW)
   ) u_ram (
      .clock   (clock),
      .we_i    (w_load_hs),
      .waddr_i (wptr_q),
      .wdata_i (bus.load_data),
      .re_i    (w_fetch_acc & (w_fetch_fault == FAULT_OK)),
      .raddr_i (w_index[RAM_AW-1:0]),
      .rdata_o (w_rdata)
   );

   assign bus.load_ready  = (state_q == ST_LOAD);
   assign bus.loaded      = loaded_q;
   assign bus.fetch_ready = w_fetch_ready;
   assign bus.instr_valid = valid_q;
   assign bus.instr_fault = fault_q;
   // Reads zero until the first fetch, since the RAM register has no reset
   assign bus.instruction = !out_seen_q            ? '0       :
                            (fault_q == FAULT_OK)  ? w_rdata  : NOP_WORD;
endmodule
`default_nettype wire
